// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply controller that borrows the shared 32-bit ALU.
// Produces the low 32 bits of a*b in a fixed 66-cycle start-to-start window.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  input  logic [31:0] core_inp1,
  input  logic [31:0] core_inp2,
  input  logic [2:0]  core_sel,
  output logic [31:0] alu_inp1,
  output logic [31:0] alu_inp2,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out
);

  localparam int unsigned DATA_W = 32;
  localparam logic [2:0]  SEL_ADD = 3'd3;
  localparam logic [2:0]  SEL_SLL = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SHF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   product_q, product_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // The ALU belongs to the core except in ADD and SHF.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    alu_inp1  = core_inp1;
    alu_inp2  = core_inp2;
    alu_sel   = core_sel;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        alu_sel  = SEL_ADD;
        alu_inp1 = acc_q;
        alu_inp2 = mcand_q;
        if (mplier_q[0]) begin
          acc_d = alu_out;
        end
        state_d = S_SHF;
      end
      S_SHF: begin
        alu_sel  = SEL_SLL;
        alu_inp1 = mcand_q;
        alu_inp2 = 32'd1;
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        // acc already holds bit 31's contribution from the preceding ADD.
        if (cnt_q == 5'd31) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU and a
// cycle-phase reference model derived from the multiply timing.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [31:0] core_inp1 = '0;
  logic [31:0] core_inp2 = '0;
  logic [2:0]  core_sel = '0;
  logic [31:0] alu_inp1;
  logic [31:0] alu_inp2;
  logic [2:0]  alu_sel;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .core_inp1 (core_inp1),
    .core_inp2 (core_inp2),
    .core_sel  (core_sel),
    .alu_inp1  (alu_inp1),
    .alu_inp2  (alu_inp2),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out)
  );

  always #5 clk = ~clk;

  // Combinational shared ALU: 3 = ADD, 4 = SLL, anything else is XOR.
  always_comb begin
    case (alu_sel)
      3'd3:    alu_out = alu_inp1 + alu_inp2;
      3'd4:    alu_out = alu_inp1 << alu_inp2[4:0];
      default: alu_out = alu_inp1 ^ alu_inp2;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = idle, 1..64 = ADD/SHF alternating, 65 = DONE.
  int          phase = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held = '0;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      exp_q.delete();
      held = '0;
      mon_en = 1'b1;
    end else if (phase == 0) begin
      if (start) begin
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        exp_q.push_back(full[31:0]);
        phase = 1;
      end
    end else if (phase == 65) begin
      phase = 0;
    end else begin
      phase = phase + 1;
    end
  end

  // Monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {31'd0, busy}, {31'd0, phase != 0});
      chk("done", {31'd0, done}, {31'd0, phase == 65});
      if (phase == 0 || phase == 65) begin
        chk("pass_inp1", alu_inp1, core_inp1);
        chk("pass_inp2", alu_inp2, core_inp2);
        chk("pass_sel", {29'd0, alu_sel}, {29'd0, core_sel});
      end else if (phase % 2 == 1) begin
        chk("add_sel", {29'd0, alu_sel}, 32'd3);
      end else begin
        chk("shf_sel", {29'd0, alu_sel}, 32'd4);
        chk("shf_inp2", alu_inp2, 32'd1);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          held = exp_q.pop_front();
          chk("product", product, held);
        end
      end else if (phase == 0) begin
        chk("product_hold", product, held);
      end
    end
  end

  // Core traffic keeps toggling, including while the multiplier owns the ALU.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      core_inp1 = $urandom;
      core_inp2 = $urandom;
      core_sel  = 3'($urandom_range(0, 7));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=%b expected=0", busy);
    end
  endtask

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1;
    a = aa;
    b = bb;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%b expected=1", done);
    end
  endtask

  task automatic mul(input logic [31:0] aa, input logic [31:0] bb);
    wait_idle();
    issue(aa, bb);
    wait_done();
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();

    mul(32'd7, 32'd6);
    tick();
    tick();
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul(32'h0001_0000, 32'h0001_0000);
    mul(32'd0, 32'h1234_5678);
    mul(32'hDEAD_BEEF, 32'd1);
    for (int i = 0; i < 12; i++) begin
      mul($urandom, $urandom);
    end

    // Starts while busy and in DONE are dropped.
    wait_idle();
    issue(32'd3, 32'd5);
    repeat (8) tick();
    issue(32'd9, 32'd9);
    wait_done();
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    tick();
    start = 1'b0;
    repeat (3) tick();

    // Reset part-way through a multiply aborts it without a done pulse.
    wait_idle();
    issue(32'd123, 32'd456);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mul(32'd4, 32'd4);

    // Reset and start together: reset wins.
    wait_idle();
    rst = 1'b1;
    start = 1'b1;
    a = 32'd11;
    b = 32'd11;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    mul(32'd2, 32'd3);
    repeat (4) tick();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_results actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
